// File: rtl/collision_scorer_if.sv
// Sprite/player inputs and score/lives outputs of the collision scorer.
// The game side drives through master; the scorer consumes through slave.
interface collision_scorer_if #(
    parameter int VWIDTH  = 12,
    parameter int NCOIN   = 3,
    parameter int NOBS    = 4,
    parameter int SCORE_W = 16
);
    logic                      frame_tick;
    logic                      play;
    logic                      clear;
    logic [1:0]                player_lane;
    logic [NCOIN*VWIDTH-1:0]   coin_voffset;
    logic [NCOIN-1:0]          coin_active;
    logic [NOBS*VWIDTH-1:0]    obs_voffset;
    logic [NOBS*2-1:0]         obs_lane;
    logic [NOBS-1:0]           obs_active;
    logic [SCORE_W-1:0]        score;
    logic [1:0]                lives;
    logic                      game_over;
    logic                      coin_pulse;
    logic                      hit_pulse;
    logic                      busy;

    modport master (
        output frame_tick, play, clear, player_lane,
               coin_voffset, coin_active, obs_voffset, obs_lane, obs_active,
        input  score, lives, game_over, coin_pulse, hit_pulse, busy
    );

    modport slave (
        input  frame_tick, play, clear, player_lane,
               coin_voffset, coin_active, obs_voffset, obs_lane, obs_active,
        output score, lives, game_over, coin_pulse, hit_pulse, busy
    );
endinterface

// File: rtl/collision_scorer.sv
// Per-frame collision/score stage: scans coins then obstacles one per clock, commits in UPDATE.
// Define SCORE_COMBO_EN to build the 1..4 coin combo multiplier; otherwise each coin scores 1.
module collision_scorer #(
    parameter int VWIDTH  = 12,
    parameter int NCOIN   = 3,
    parameter int NOBS    = 4,
    parameter int HIT_LO  = 180,
    parameter int HIT_HI  = 260,
    parameter int SCORE_W = 16,
    parameter int LIVES   = 3
) (
    input  logic              clk,
    input  logic              rst,
    collision_scorer_if.slave bus
);
    localparam int NITEMS = NCOIN + NOBS;
    localparam int IDX_W  = $clog2(NITEMS);
    localparam int NSLOT  = 2 ** IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_OVER   = 2'd3;

    localparam logic [IDX_W-1:0]          LAST_IDX   = IDX_W'(NITEMS - 1);
    localparam logic [IDX_W-1:0]          FIRST_OBS  = IDX_W'(NCOIN);
    localparam logic signed [VWIDTH-1:0]  WIN_LO     = VWIDTH'(HIT_LO);
    localparam logic signed [VWIDTH-1:0]  WIN_HI     = VWIDTH'(HIT_HI);
    localparam logic [1:0]                LIVES_INIT = 2'(LIVES);
    localparam logic [SCORE_W-1:0]        SCORE_MAX  = '1;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SCORE_W-1:0] score_q, score_d, acc_score_q, acc_score_d;
    logic [1:0]         lives_q, lives_d, acc_lives_q, acc_lives_d;
    logic [NSLOT-1:0]   latched_q, latched_d;
    logic               game_over_q, game_over_d;
    logic               coin_pulse_q, coin_pulse_d;
    logic               hit_pulse_q, hit_pulse_d;
`ifdef SCORE_COMBO_EN
    logic [2:0]         mult_q, mult_d;
`endif

    // Coins and obstacles flattened into one item list, coins first.
    logic signed [VWIDTH-1:0] item_voff   [NSLOT];
    logic [1:0]               item_lane   [NSLOT];
    logic [NSLOT-1:0]         item_active;

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            item_voff[i]   = '0;
            item_lane[i]   = 2'd0;
            item_active[i] = 1'b0;
        end
        for (int i = 0; i < NCOIN; i++) begin
            item_voff[i]   = bus.coin_voffset[i*VWIDTH +: VWIDTH];
            item_lane[i]   = 2'(i);
            item_active[i] = bus.coin_active[i];
        end
        for (int j = 0; j < NOBS; j++) begin
            item_voff[NCOIN+j]   = bus.obs_voffset[j*VWIDTH +: VWIDTH];
            item_lane[NCOIN+j]   = bus.obs_lane[j*2 +: 2];
            item_active[NCOIN+j] = bus.obs_active[j];
        end
    end

    logic [1:0]               player_lane_eff;
    logic signed [VWIDTH-1:0] cur_voff;
    logic                     cur_active, cur_is_coin, cur_lane_ok, cur_below, cur_in_win;
    logic [SCORE_W-1:0]       coin_inc;
    logic [SCORE_W:0]         score_sum;

    assign player_lane_eff = (bus.player_lane == 2'd3) ? 2'd1 : bus.player_lane;
    assign cur_voff        = item_voff[idx_q];
    assign cur_active      = item_active[idx_q];
    assign cur_is_coin     = idx_q < FIRST_OBS;
    assign cur_lane_ok     = item_lane[idx_q] == player_lane_eff;
    assign cur_below       = cur_voff < WIN_LO;
    assign cur_in_win      = !cur_below && (cur_voff <= WIN_HI);
`ifdef SCORE_COMBO_EN
    assign coin_inc        = SCORE_W'(mult_q);
`else
    assign coin_inc        = SCORE_W'(1);
`endif
    assign score_sum       = {1'b0, acc_score_q} + {1'b0, coin_inc};

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        score_d      = score_q;
        lives_d      = lives_q;
        acc_score_d  = acc_score_q;
        acc_lives_d  = acc_lives_q;
        latched_d    = latched_q;
        game_over_d  = game_over_q;
        coin_pulse_d = 1'b0;
        hit_pulse_d  = 1'b0;
`ifdef SCORE_COMBO_EN
        mult_d       = mult_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick && bus.play) begin
                    state_d     = ST_SCAN;
                    idx_d       = '0;
                    acc_score_d = score_q;
                    acc_lives_d = lives_q;
                end
            end
            ST_SCAN: begin
                // A slot that left the screen or respawned above the window may score again.
                if (!cur_active || cur_below) begin
                    latched_d[idx_q] = 1'b0;
                end else if (cur_in_win && cur_lane_ok && !latched_q[idx_q]) begin
                    latched_d[idx_q] = 1'b1;
                    if (cur_is_coin) begin
                        coin_pulse_d = 1'b1;
                        acc_score_d  = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
`ifdef SCORE_COMBO_EN
                        mult_d       = (mult_q == 3'd4) ? 3'd4 : mult_q + 3'd1;
`endif
                    end else begin
                        hit_pulse_d  = 1'b1;
                        acc_lives_d  = (acc_lives_q == 2'd0) ? 2'd0 : acc_lives_q - 2'd1;
`ifdef SCORE_COMBO_EN
                        mult_d       = 3'd1;
`endif
                    end
                end
`ifdef SCORE_COMBO_EN
                if (cur_is_coin && cur_active && cur_lane_ok && !cur_below && !cur_in_win
                    && !latched_q[idx_q]) begin
                    mult_d = 3'd1;
                end
`endif
                if (idx_q == LAST_IDX) state_d = ST_UPDATE;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_UPDATE: begin
                score_d = acc_score_q;
                lives_d = acc_lives_q;
                if (acc_lives_q == 2'd0) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (bus.clear) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            score_d      = '0;
            lives_d      = LIVES_INIT;
            acc_score_d  = '0;
            acc_lives_d  = LIVES_INIT;
            latched_d    = '0;
            game_over_d  = 1'b0;
            coin_pulse_d = 1'b0;
            hit_pulse_d  = 1'b0;
`ifdef SCORE_COMBO_EN
            mult_d       = 3'd1;
`endif
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            acc_score_q  <= '0;
            acc_lives_q  <= LIVES_INIT;
            latched_q    <= '0;
            game_over_q  <= 1'b0;
            coin_pulse_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
`ifdef SCORE_COMBO_EN
            mult_q       <= 3'd1;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            acc_score_q  <= acc_score_d;
            acc_lives_q  <= acc_lives_d;
            latched_q    <= latched_d;
            game_over_q  <= game_over_d;
            coin_pulse_q <= coin_pulse_d;
            hit_pulse_q  <= hit_pulse_d;
`ifdef SCORE_COMBO_EN
            mult_q       <= mult_d;
`endif
        end
    end

    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.game_over  = game_over_q;
    assign bus.coin_pulse = coin_pulse_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.busy       = (state_q == ST_SCAN) || (state_q == ST_UPDATE);
endmodule

// File: tb/tb_collision_scorer.sv
// Directed bench for collision_scorer: a frame-level model checked every cycle plus literal checks.
// A second instance with a 3-bit score shares all inputs to exercise score saturation quickly.
module tb_collision_scorer;
`ifdef SCORE_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif
    localparam int NITEMS = 7;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    collision_scorer_if                  bus ();
    collision_scorer_if #(.SCORE_W(3))   bus_s ();

    collision_scorer u_dut (.clk(clk), .rst(rst), .bus(bus));
    collision_scorer #(.SCORE_W(3)) u_small (.clk(clk), .rst(rst), .bus(bus_s));

    assign bus_s.frame_tick   = bus.frame_tick;
    assign bus_s.play         = bus.play;
    assign bus_s.clear        = bus.clear;
    assign bus_s.player_lane  = bus.player_lane;
    assign bus_s.coin_voffset = bus.coin_voffset;
    assign bus_s.coin_active  = bus.coin_active;
    assign bus_s.obs_voffset  = bus.obs_voffset;
    assign bus_s.obs_lane     = bus.obs_lane;
    assign bus_s.obs_active   = bus.obs_active;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a whole frame is evaluated when the tick is accepted,
    // then replayed as per-item pulses and a commit eight edges later.
    int  m_score, m_score_s, m_lives, m_mult, phase;
    bit  m_over, m_busy, m_coin, m_hit, m_valid;
    bit  m_latch [NITEMS];
    bit  f_coin  [NITEMS];
    bit  f_hit   [NITEMS];
    int  f_score, f_score_s, f_lives;

    always @(posedge clk) begin : model
        int pl, ln, v, inc;
        bit coin, act, inwin;
        logic signed [11:0] v12;
        if (rst || bus.clear) begin
            m_score = 0; m_score_s = 0; m_lives = 3; m_mult = 1; phase = -1;
            m_over = 0; m_busy = 0; m_coin = 0; m_hit = 0; m_valid = 1;
            for (int i = 0; i < NITEMS; i++) m_latch[i] = 0;
        end else begin
            m_coin = 0;
            m_hit  = 0;
            if (phase >= 0) begin
                phase++;
                if (phase <= NITEMS) begin
                    m_coin = f_coin[phase-1];
                    m_hit  = f_hit[phase-1];
                end else begin
                    m_score = f_score; m_score_s = f_score_s; m_lives = f_lives;
                    m_busy = 0; m_over = (f_lives == 0); phase = -1;
                end
            end else if (!m_over && bus.frame_tick && bus.play) begin
                f_score = m_score; f_score_s = m_score_s; f_lives = m_lives;
                pl = (bus.player_lane == 2'd3) ? 1 : int'(bus.player_lane);
                for (int i = 0; i < NITEMS; i++) begin
                    coin = (i < 3);
                    if (coin) begin
                        v12 = bus.coin_voffset[i*12 +: 12];
                        act = bus.coin_active[i];
                        ln  = i;
                    end else begin
                        v12 = bus.obs_voffset[(i-3)*12 +: 12];
                        act = bus.obs_active[i-3];
                        ln  = int'(bus.obs_lane[(i-3)*2 +: 2]);
                    end
                    v = int'(v12);
                    inwin = (v >= 180) && (v <= 260);
                    f_coin[i] = 0;
                    f_hit[i]  = 0;
                    if (!act || v < 180) begin
                        m_latch[i] = 0;
                    end else if (inwin && ln == pl && !m_latch[i]) begin
                        m_latch[i] = 1;
                        if (coin) begin
                            f_coin[i] = 1;
                            inc = COMBO ? m_mult : 1;
                            f_score   = (f_score + inc > 65535) ? 65535 : f_score + inc;
                            f_score_s = (f_score_s + inc > 7) ? 7 : f_score_s + inc;
                            if (COMBO && m_mult < 4) m_mult++;
                        end else begin
                            f_hit[i] = 1;
                            f_lives  = (f_lives > 0) ? f_lives - 1 : 0;
                            m_mult   = 1;
                        end
                    end else if (coin && act && ln == pl && v > 260) begin
                        m_mult = 1;
                    end
                end
                phase  = 0;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("score",       int'(bus.score),        m_score);
            check("lives",       int'(bus.lives),        m_lives);
            check("game_over",   int'(bus.game_over),    int'(m_over));
            check("busy",        int'(bus.busy),         int'(m_busy));
            check("coin_pulse",  int'(bus.coin_pulse),   int'(m_coin));
            check("hit_pulse",   int'(bus.hit_pulse),    int'(m_hit));
            check("s_score",     int'(bus_s.score),      m_score_s);
            check("s_lives",     int'(bus_s.lives),      m_lives);
            check("s_game_over", int'(bus_s.game_over),  int'(m_over));
            check("s_busy",      int'(bus_s.busy),       int'(m_busy));
            check("s_coin",      int'(bus_s.coin_pulse), int'(m_coin));
            check("s_hit",       int'(bus_s.hit_pulse),  int'(m_hit));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_coin(input int i, input bit act, input int v);
        bus.coin_active[i]           = act;
        bus.coin_voffset[i*12 +: 12] = 12'(v);
    endtask

    task automatic set_obs(input int j, input bit act, input int ln, input int v);
        bus.obs_active[j]           = act;
        bus.obs_lane[j*2 +: 2]      = 2'(ln);
        bus.obs_voffset[j*12 +: 12] = 12'(v);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    // One tick then eight edges; optionally drops play and re-ticks mid-scan.
    task automatic frame(input bit mid, output int nc, output int nh,
                         output int first_c, output int nbusy, output int sc7);
        nc = 0; nh = 0; first_c = -1; nbusy = 0; sc7 = -1;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        nbusy += int'(bus.busy);
        for (int s = 1; s <= 8; s++) begin
            if (mid && s == 3) begin bus.play = 1'b0; bus.frame_tick = 1'b1; end
            if (mid && s == 4) bus.frame_tick = 1'b0;
            step(1);
            if (bus.coin_pulse) begin
                nc++;
                if (first_c < 0) first_c = s;
            end
            nh += int'(bus.hit_pulse);
            if (s < 8) nbusy += int'(bus.busy);
            if (s == 7) sc7 = int'(bus.score);
        end
        bus.play = 1'b1;
    endtask

    int nc, nh, fc, nb, sc7;

    initial begin
        rst = 1'b1;
        bus.frame_tick = 0; bus.play = 1; bus.clear = 0; bus.player_lane = 0;
        bus.coin_voffset = '0; bus.coin_active = '0;
        bus.obs_voffset = '0; bus.obs_lane = '0; bus.obs_active = '0;
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_score", int'(bus.score), 0);
        check("rst_lives", int'(bus.lives), 3);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_busy", int'(bus.busy), 0);

        // T1: single coin in lane 0
        set_coin(0, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t1_coin_pulses", nc, 1);
        check("t1_first_pulse_cycle", fc, 1);
        check("t1_busy_cycles", nb, 8);
        check("t1_score_before_update", sc7, 0);
        check("t1_score", int'(bus.score), 1);
        check("t1_lives", int'(bus.lives), 3);
        check("t1_busy_after", int'(bus.busy), 0);

        // tick with play low is ignored
        bus.play = 1'b0; bus.frame_tick = 1'b1;
        step(1);
        bus.play = 1'b1; bus.frame_tick = 1'b0;
        check("noplay_busy", int'(bus.busy), 0);

        // T2: held coin credits once; respawn re-arms it
        for (int k = 0; k < 3; k++) begin
            frame(k == 1, nc, nh, fc, nb, sc7);
            check("t2_held_pulses", nc, 0);
            check("t2_held_score", int'(bus.score), 1);
            if (k == 1) begin
                step(1);
                check("t2_tick_not_queued", int'(bus.busy), 0);
            end
        end
        set_coin(0, 1, -140);
        frame(0, nc, nh, fc, nb, sc7);
        check("t2_respawn_score", int'(bus.score), 1);
        set_coin(0, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t2_recredit_pulses", nc, 1);
        check("t2_recredit_score", int'(bus.score), COMBO ? 3 : 2);

        // Window boundaries, player lane 3 treated as mid
        set_coin(0, 0, 0);
        bus.player_lane = 2'd3;
        set_coin(1, 1, 179);
        frame(0, nc, nh, fc, nb, sc7);
        check("b_179_pulses", nc, 0);
        set_coin(1, 1, 180);
        frame(0, nc, nh, fc, nb, sc7);
        check("b_180_pulses", nc, 1);
        check("b_180_score", int'(bus.score), COMBO ? 6 : 3);
        set_coin(1, 0, 180);
        frame(0, nc, nh, fc, nb, sc7);
        set_coin(1, 1, 261);
        frame(0, nc, nh, fc, nb, sc7);
        check("b_261_pulses", nc, 0);
        set_coin(1, 1, 260);
        frame(0, nc, nh, fc, nb, sc7);
        check("b_260_score", int'(bus.score), COMBO ? 7 : 4);
        check("b_260_small_score", int'(bus_s.score), COMBO ? 7 : 4);

        // T3: obstacles, lives, game over
        set_coin(1, 0, 0);
        bus.player_lane = 2'd1;
        set_obs(0, 1, 1, 300);
        set_obs(1, 1, 2, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t3_miss_hits", nh, 0);
        check("t3_miss_lives", int'(bus.lives), 3);
        set_obs(0, 1, 1, 250);
        frame(0, nc, nh, fc, nb, sc7);
        check("t3_hit_pulses", nh, 1);
        check("t3_hit_lives", int'(bus.lives), 2);
        check("t3_hit_game_over", int'(bus.game_over), 0);
        set_obs(1, 1, 1, 200);
        set_obs(2, 1, 1, 190);
        set_obs(3, 1, 1, 185);
        frame(0, nc, nh, fc, nb, sc7);
        check("t3_multi_hits", nh, 3);
        check("t3_multi_lives", int'(bus.lives), 0);
        check("t3_game_over", int'(bus.game_over), 1);
        set_coin(1, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t3_over_busy", nb, 0);
        check("t3_over_pulses", nc, 0);
        check("t3_over_score", int'(bus.score), COMBO ? 7 : 4);
        check("t3_over_game_over", int'(bus.game_over), 1);

        // T4: clear from OVER, build a score, then clear mid-scan
        for (int j = 0; j < 4; j++) set_obs(j, 0, 0, 0);
        set_coin(1, 0, 0);
        pulse_clear();
        check("t4_clear_score", int'(bus.score), 0);
        check("t4_clear_lives", int'(bus.lives), 3);
        check("t4_clear_game_over", int'(bus.game_over), 0);
        bus.player_lane = 2'd0;
        for (int k = 0; k < 5; k++) begin
            set_coin(0, 1, 200);
            frame(0, nc, nh, fc, nb, sc7);
            set_coin(0, 1, -140);
            frame(0, nc, nh, fc, nb, sc7);
        end
        check("t4_built_score", int'(bus.score), COMBO ? 14 : 5);
        set_coin(0, 1, 200);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(3);
        check("t4_midscan_busy", int'(bus.busy), 1);
        pulse_clear();
        check("t4_abort_score", int'(bus.score), 0);
        check("t4_abort_lives", int'(bus.lives), 3);
        check("t4_abort_busy", int'(bus.busy), 0);
        check("t4_abort_game_over", int'(bus.game_over), 0);
        step(1);
        check("t4_abort_stays_idle", int'(bus.busy), 0);

        // T5: score saturation (3-bit instance saturates at 7)
        for (int k = 0; k < 9; k++) begin
            set_coin(0, 1, 200);
            frame(0, nc, nh, fc, nb, sc7);
            set_coin(0, 1, -140);
            frame(0, nc, nh, fc, nb, sc7);
        end
        check("t5_score", int'(bus.score), COMBO ? 30 : 9);
        check("t5_small_saturated", int'(bus_s.score), 7);

        // T6: consecutive-frame coins across lanes, then hit+coin in one frame
        pulse_clear();
        set_coin(0, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f1_score", int'(bus.score), 1);
        bus.player_lane = 2'd1; set_coin(0, 0, 0); set_coin(1, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f2_score", int'(bus.score), COMBO ? 3 : 2);
        bus.player_lane = 2'd2; set_coin(1, 0, 0); set_coin(2, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f3_score", int'(bus.score), COMBO ? 6 : 3);
        bus.player_lane = 2'd0; set_coin(2, 0, 0); set_coin(0, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f4_score", int'(bus.score), COMBO ? 10 : 4);
        check("t6_f4_small_score", int'(bus_s.score), COMBO ? 7 : 4);
        bus.player_lane = 2'd1; set_coin(1, 1, 200); set_obs(0, 1, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f5_coin_pulses", nc, 1);
        check("t6_f5_hit_pulses", nh, 1);
        check("t6_f5_score", int'(bus.score), COMBO ? 14 : 5);
        check("t6_f5_lives", int'(bus.lives), 2);
        bus.player_lane = 2'd2; set_obs(0, 0, 0, 0); set_coin(2, 1, 200);
        frame(0, nc, nh, fc, nb, sc7);
        check("t6_f6_score", int'(bus.score), COMBO ? 15 : 6);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
